// File: rtl/onlab_pkg.sv
// Shared types and constants for the onlab UART transmit path.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package onlab_pkg;

  localparam int BYTE_W                       = 8;
  localparam int TX_FIFO_DEPTH_DEFAULT        = 16;
  localparam int TX_FIFO_BUSY_TIMEOUT_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } tx_fifo_state_e;

endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: circular byte store with wrap-bit pointers; full/empty derive from pointer registers only.
// Latency: a push is visible (empty clears) after the edge that samples it; the head byte is read combinationally.
// Backpressure: a push while full or a pop while empty is ignored and leaves all state unchanged.
module byte_fifo
  import onlab_pkg::*;
#(
  parameter int DEPTH = TX_FIFO_DEPTH_DEFAULT
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     push_vld,
  input  logic [BYTE_W-1:0]        push_dat,
  input  logic                     pop_vld,
  output logic [BYTE_W-1:0]        pop_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [BYTE_W-1:0] mem [DEPTH];
  logic              do_push;
  logic              do_pop;

  // MSB of each pointer is the wrap bit: equal LSBs with differing MSBs means a full lap ahead.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign level   = wr_ptr - rd_ptr;
  assign do_push = push_vld && !full;
  assign do_pop  = pop_vld && !empty;
  assign pop_dat = mem[rd_ptr[AW-1:0]];

  // Each pointer advances only on its own accepted operation.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: the pointers mask stale entries.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffers response bytes and launches them one at a time to the UART; UART_TX_FIFO_STATUS_EN adds level/overflow status.
// Latency: write sampled at E0 -> pop at E1 -> transmit_o high between E1 and E2 (2 cycles).
// Backpressure: writes while full are dropped; launches are paced by tx_busy_i with a lost-launch timeout.
module uart_tx_fifo
  import onlab_pkg::*;
#(
  parameter int DEPTH        = TX_FIFO_DEPTH_DEFAULT,
  parameter int BUSY_TIMEOUT = TX_FIFO_BUSY_TIMEOUT_DEFAULT
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   wr_valid_i,
  input  logic [BYTE_W-1:0]      wr_data_i,
  output logic                   full_o,
  output logic                   empty_o,
  input  logic                   tx_busy_i,
  output logic                   transmit_o,
  output logic [BYTE_W-1:0]      tx_byte_o
`ifdef UART_TX_FIFO_STATUS_EN
  ,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   overflow_o,
  input  logic                   clr_overflow_i
`endif
);

  localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

  tx_fifo_state_e    state_q;
  tx_fifo_state_e    state_d;
  logic [CNT_W-1:0]  tmo_cnt_q;
  logic [CNT_W-1:0]  tmo_cnt_d;
  logic              pop;
  logic [BYTE_W-1:0] head_dat;

`ifdef UART_TX_FIFO_STATUS_EN
  logic [$clog2(DEPTH):0] fifo_level;
`endif

  byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .push_vld (wr_valid_i),
    .push_dat (wr_data_i),
    .pop_vld  (pop),
    .pop_dat  (head_dat),
    .full     (full_o),
    .empty    (empty_o),
`ifdef UART_TX_FIFO_STATUS_EN
    .level    (fifo_level)
`else
    .level    ()
`endif
  );

  // Launch sequencer: pop, pulse transmit, then wait for the UART frame (or the timeout) before the next pop.
  always_comb begin
    state_d    = state_q;
    tmo_cnt_d  = tmo_cnt_q;
    pop        = 1'b0;
    transmit_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty_o) begin
          pop     = 1'b1;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        transmit_o = 1'b1;
        tmo_cnt_d  = '0;
        state_d    = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy_i) begin
          state_d = WAIT_DONE;
        end else if (tmo_cnt_q == CNT_W'(BUSY_TIMEOUT - 1)) begin
          state_d = IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, timeout counter and the launched byte; tx_byte_o holds until the next pop.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      tmo_cnt_q <= '0;
      tx_byte_o <= '0;
    end else begin
      state_q   <= state_d;
      tmo_cnt_q <= tmo_cnt_d;
      if (pop) tx_byte_o <= head_dat;
    end
  end

`ifdef UART_TX_FIFO_STATUS_EN
  assign level_o = fifo_level;

  // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      overflow_o <= 1'b0;
    end else if (wr_valid_i && full_o) begin
      overflow_o <= 1'b1;
    end else if (clr_overflow_i) begin
      overflow_o <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed and random stimulus against a queue/event-time reference model.
// Latency: checks every cycle 1 time unit after the rising edge.
// Backpressure: a behavioural UART drives tx_busy_i (normal frame, stuck high, or never busy).
module tb_uart_tx_fifo;

  localparam int DEPTH = 4;
  localparam int TMO   = 8;

  logic       clk_i      = 1'b0;
  logic       rst_n_i    = 1'b1;
  logic       wr_valid_i = 1'b0;
  logic [7:0] wr_data_i  = 8'h00;
  logic       tx_busy_i  = 1'b0;
  logic       clr_req    = 1'b0;
  logic       full_o;
  logic       empty_o;
  logic       transmit_o;
  logic [7:0] tx_byte_o;
`ifdef UART_TX_FIFO_STATUS_EN
  logic [2:0] level_o;
  logic       overflow_o;
`endif

  uart_tx_fifo #(
    .DEPTH        (DEPTH),
    .BUSY_TIMEOUT (TMO)
  ) dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .wr_valid_i     (wr_valid_i),
    .wr_data_i      (wr_data_i),
    .full_o         (full_o),
    .empty_o        (empty_o),
    .tx_busy_i      (tx_busy_i),
    .transmit_o     (transmit_o),
    .tx_byte_o      (tx_byte_o)
`ifdef UART_TX_FIFO_STATUS_EN
    ,
    .level_o        (level_o),
    .overflow_o     (overflow_o),
    .clr_overflow_i (clr_req)
`endif
  );

  always #5 clk_i = ~clk_i;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: stored bytes, plus the edge times of the current launch.
  logic [7:0] q[$];
  int         e_now       = 0;
  int         pop_edge    = -100;
  bit         outstanding = 0;
  bit         busy_seen   = 0;
  int         next_ok     = 0;
  logic [7:0] m_byte      = 8'h00;
  bit         m_ovf       = 0;

  // Behavioural UART: 0 normal frame, 1 stuck busy, 2 never busy.
  int busy_mode = 0;
  int cfg_delay = 3;
  int cfg_len   = 5;
  bit rnd_cfg   = 0;
  int u_wait    = 0;
  int u_len     = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", tag, got, exp, e_now);
    end
  endtask

  task automatic model_reset();
    q.delete();
    pop_edge    = -100;
    outstanding = 0;
    busy_seen   = 0;
    next_ok     = 0;
    m_byte      = 8'h00;
    m_ovf       = 0;
  endtask

  // Apply one rising edge with the inputs that were stable before it.
  task automatic model_edge(input bit wv, input logic [7:0] wd, input bit b, input bit clr);
    bit was_full;
    was_full = (q.size() == DEPTH);
    // The launched byte retires when busy falls after being seen, or when the busy window expires.
    if (outstanding) begin
      if (!busy_seen) begin
        if (e_now >= pop_edge + 2 && b) begin
          busy_seen = 1;
        end else if (e_now == pop_edge + 1 + TMO) begin
          outstanding = 0;
          next_ok     = e_now + 1;
        end
      end else if (!b) begin
        outstanding = 0;
        next_ok     = e_now + 1;
      end
    end
    if (!outstanding && e_now >= next_ok && q.size() > 0) begin
      m_byte      = q.pop_front();
      outstanding = 1;
      busy_seen   = 0;
      pop_edge    = e_now;
    end
    if (wv && !was_full) q.push_back(wd);
    if (wv && was_full) m_ovf = 1;
    else if (clr)       m_ovf = 0;
  endtask

  task automatic check_all();
    chk("transmit", transmit_o, (outstanding && pop_edge == e_now));
    chk("tx_byte",  tx_byte_o,  m_byte);
    chk("empty",    empty_o,    (q.size() == 0));
    chk("full",     full_o,     (q.size() == DEPTH));
`ifdef UART_TX_FIFO_STATUS_EN
    chk("level",    level_o,    q.size());
    chk("overflow", overflow_o, m_ovf);
`endif
  endtask

  task automatic uart_update();
    if (busy_mode == 1) begin
      tx_busy_i = 1'b1;
    end else if (busy_mode == 2) begin
      tx_busy_i = 1'b0;
    end else begin
      if (transmit_o === 1'b1) begin
        if (rnd_cfg) begin
          cfg_delay = $urandom_range(1, 11);
          cfg_len   = $urandom_range(1, 8);
        end
        u_wait = cfg_delay;
        u_len  = 0;
      end
      if (u_wait > 0) begin
        u_wait--;
        if (u_wait == 0) u_len = cfg_len;
      end
      tx_busy_i = (u_len > 0);
      if (u_len > 0) u_len--;
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    e_now++;
    model_edge(wr_valid_i, wr_data_i, tx_busy_i, clr_req);
    #1;
    check_all();
    uart_update();
    wr_valid_i = 1'b0;
    clr_req    = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] b);
    wr_valid_i = 1'b1;
    wr_data_i  = b;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Asynchronous reset between edges: outputs must reach reset values without a clock.
  task automatic do_reset();
    rst_n_i = 1'b0;
    #1;
    model_reset();
    check_all();
    #3;
    rst_n_i = 1'b1;
  endtask

  initial begin
    #1 rst_n_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    model_reset();
    check_all();
    @(negedge clk_i) rst_n_i = 1'b1;

    // Single byte, busy rises 3 cycles after launch.
    busy_mode = 0; cfg_delay = 3; cfg_len = 5;
    write_byte(8'hA5);
    idle(20);

    // Burst of five, 10-cycle frames.
    cfg_delay = 2; cfg_len = 10;
    for (int i = 1; i <= 5; i++) write_byte(8'(i));
    idle(90);

    // Overflow with busy stuck high, then drop-and-clear together, then clear alone.
    busy_mode = 1;
    for (int i = 0; i < 6; i++) write_byte(8'h10 + 8'(i));
    idle(3);
    wr_valid_i = 1'b1; wr_data_i = 8'hEE; clr_req = 1'b1;
    step();
    clr_req = 1'b1;
    step();
    busy_mode = 0; cfg_delay = 2; cfg_len = 3;
    idle(60);

    // Lost launches: busy never rises.
    busy_mode = 2;
    write_byte(8'h31);
    write_byte(8'h32);
    idle(40);

    // Reset while transmit_o is high.
    busy_mode = 0; cfg_delay = 2; cfg_len = 4;
    write_byte(8'h44);
    step();
    do_reset();
    idle(15);

    // Reset during a long frame with bytes still queued; nothing may launch afterwards.
    cfg_delay = 2; cfg_len = 20;
    write_byte(8'h51); write_byte(8'h52); write_byte(8'h53);
    idle(7);
    do_reset();
    idle(30);

    // Wrap-around: 12 spaced bytes through a 4-entry store.
    cfg_delay = 2; cfg_len = 3;
    for (int i = 0; i < 12; i++) begin
      write_byte(8'hC0 + 8'(i));
      idle(8);
    end
    idle(20);

    // Random traffic with varying UART behaviour.
    rnd_cfg = 1;
    for (int blk = 0; blk < 10; blk++) begin
      int r;
      r = $urandom_range(0, 9);
      busy_mode = (r < 7) ? 0 : ((r < 9) ? 2 : 1);
      for (int i = 0; i < 80; i++) begin
        if ($urandom_range(0, 99) < 30) begin
          wr_valid_i = 1'b1;
          wr_data_i  = 8'($urandom_range(0, 255));
        end
        if ($urandom_range(0, 99) < 5) clr_req = 1'b1;
        step();
      end
    end

    // Drain and confirm the store empties.
    busy_mode = 0; rnd_cfg = 0; cfg_delay = 2; cfg_len = 3;
    idle(150);
    chk("drained", empty_o, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
